// File: rtl/trace_seq.sv
// ---------------------------------------------------------------------------
// trace_seq
// Generates per-instruction trace IDs and stage-entry strobes for the
// four-stage I/X/M/R pipeline so that a pipeline logger emits exactly one
// I, X and R record per instruction, even across stalls and branch flushes.
//
// Optional feature: define TRACE_FLUSH_LOG_EN to report instructions that
// are killed out of the I stage on kill_v/kill_id. Without the macro both
// outputs are tied to zero and no kill register exists.
//
// Every strobe and every stage ID is registered. A strobe is high for the
// single cycle after a valid entry moves into its stage. The stage ID keeps
// its last value while the stage is empty or holding.
// ---------------------------------------------------------------------------
module trace_seq #(
    parameter int ID_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic            stall,
    input  logic            flush,
    output logic            inst_v_i,
    output logic            inst_v_x,
    output logic            inst_v_m,
    output logic            inst_v_r,
    output logic [ID_W-1:0] ci,
    output logic [ID_W-1:0] cx,
    output logic [ID_W-1:0] cm,
    output logic [ID_W-1:0] cr,
    output logic            kill_v,
    output logic [ID_W-1:0] kill_id
);

    // Occupancy of I, X and M. R needs no separate valid bit: R always takes
    // M's contents, so an R entry lasts exactly one cycle and inst_v_r
    // serves as its valid flag.
    logic            v_i;
    logic            v_x;
    logic            v_m;
    logic [ID_W-1:0] next_id;
    logic            fire;

    // Fetch may only hand over an instruction when the pipe is advancing.
    assign issue_ready = !stall && !flush;
    assign fire        = issue_valid && issue_ready;

    // I stage: flush kills the resident entry, stall holds it, otherwise
    // I is refilled from fetch (or emptied) and the ID counter advances.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_i      <= 1'b0;
            ci       <= '0;
            inst_v_i <= 1'b0;
            next_id  <= '0;
        end else begin
            inst_v_i <= fire;
            if (flush) begin
                v_i <= 1'b0;
            end else if (!stall) begin
                v_i <= fire;
                if (fire) begin
                    ci      <= next_id;
                    next_id <= next_id + ID_W'(1);
                end
            end
        end
    end

    // X stage: stall holds the entry (with or without flush), a lone flush
    // inserts a bubble, otherwise X takes whatever was in I.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_x      <= 1'b0;
            cx       <= '0;
            inst_v_x <= 1'b0;
        end else if (stall) begin
            inst_v_x <= 1'b0;
        end else if (flush) begin
            v_x      <= 1'b0;
            inst_v_x <= 1'b0;
        end else begin
            v_x      <= v_i;
            inst_v_x <= v_i;
            if (v_i) begin
                cx <= ci;
            end
        end
    end

    // M stage: a stall sends a bubble into M. Otherwise M takes X, which
    // includes the branch itself when it resolves and flushes.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_m      <= 1'b0;
            cm       <= '0;
            inst_v_m <= 1'b0;
        end else if (stall) begin
            v_m      <= 1'b0;
            inst_v_m <= 1'b0;
        end else begin
            v_m      <= v_x;
            inst_v_m <= v_x;
            if (v_x) begin
                cm <= cx;
            end
        end
    end

    // R stage: always drains M regardless of stall or flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            cr       <= '0;
            inst_v_r <= 1'b0;
        end else begin
            inst_v_r <= v_m;
            if (v_m) begin
                cr <= cm;
            end
        end
    end

`ifdef TRACE_FLUSH_LOG_EN
    // Report the ID of an instruction killed out of I, one cycle after the
    // flush. A flush of an empty I stage kills nothing.
    always_ff @(posedge clk) begin
        if (reset) begin
            kill_v  <= 1'b0;
            kill_id <= '0;
        end else begin
            kill_v <= flush && v_i;
            if (flush && v_i) begin
                kill_id <= ci;
            end
        end
    end
`else
    assign kill_v  = 1'b0;
    assign kill_id = '0;
`endif

endmodule
